// File: rtl/edge_detect_multi.sv
// Multi-channel synchronised, glitch-filtered edge detector with
// qualified pulses, sticky W1C flags, irq and a saturating event counter.
module edge_detect_multi #(
  parameter int CHANNELS      = 8,
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 4,
  parameter int COUNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [CHANNELS-1:0]    in,
  input  logic [CHANNELS-1:0]    rise_en,
  input  logic [CHANNELS-1:0]    fall_en,
  input  logic [CHANNELS-1:0]    flag_clear,
  input  logic                   count_clear,
  output logic [CHANNELS-1:0]    level,
  output logic [CHANNELS-1:0]    rise_pulse,
  output logic [CHANNELS-1:0]    fall_pulse,
  output logic [CHANNELS-1:0]    edge_pulse,
  output logic [CHANNELS-1:0]    flags,
  output logic                   irq,
  output logic [COUNT_WIDTH-1:0] event_count
);

  localparam int CW = (FILTER_CYCLES > 0) ?
                      $clog2(FILTER_CYCLES + 1) : 1;
  localparam int NW = $clog2(CHANNELS + 1);
  localparam int SW = ((COUNT_WIDTH > NW) ?
                       COUNT_WIDTH : NW) + 1;
  localparam logic [COUNT_WIDTH-1:0] CMAX = '1;

  logic [CHANNELS-1:0]    r_sync [SYNC_STAGES];
  logic [CHANNELS-1:0]    w_sync_q;
  logic [CHANNELS-1:0]    w_level_nxt;
  logic [CHANNELS-1:0]    r_level;
  logic [CHANNELS-1:0]    r_rise;
  logic [CHANNELS-1:0]    r_fall;
  logic [CHANNELS-1:0]    r_flags;
  logic [COUNT_WIDTH-1:0] r_count;
  logic [NW-1:0]          w_n;
  logic [SW-1:0]          w_sum;
  logic [COUNT_WIDTH-1:0] w_count_nxt;

  // Plain flop chain, nothing between stages.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < SYNC_STAGES; s++)
        r_sync[s] <= '0;
    end else begin
      r_sync[0] <= in;
      for (int s = 1; s < SYNC_STAGES; s++)
        r_sync[s] <= r_sync[s-1];
    end
  end

  assign w_sync_q = r_sync[SYNC_STAGES-1];

  generate
    if (FILTER_CYCLES == 0) begin : g_nofilt
      assign w_level_nxt = w_sync_q;
    end else begin : g_filt
      logic [CW-1:0]       r_cnt [CHANNELS];
      logic [CHANNELS-1:0] w_diff;
      logic [CHANNELS-1:0] w_accept;

      always_comb begin
        w_diff   = w_sync_q ^ r_level;
        w_accept = '0;
        for (int c = 0; c < CHANNELS; c++)
          w_accept[c] = w_diff[c] &&
            (r_cnt[c] == CW'(FILTER_CYCLES - 1));
      end

      assign w_level_nxt = r_level ^ w_accept;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          for (int c = 0; c < CHANNELS; c++)
            r_cnt[c] <= '0;
        end else begin
          for (int c = 0; c < CHANNELS; c++) begin
            if (!w_diff[c] || w_accept[c])
              r_cnt[c] <= '0;
            else
              r_cnt[c] <= r_cnt[c] + CW'(1);
          end
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_level <= '0;
      r_rise  <= '0;
      r_fall  <= '0;
    end else begin
      r_level <= w_level_nxt;
      r_rise  <= w_level_nxt & ~r_level;
      r_fall  <= ~w_level_nxt & r_level;
    end
  end

  assign edge_pulse = (r_rise & rise_en) |
                      (r_fall & fall_en);

  always_comb begin
    w_n = '0;
    for (int i = 0; i < CHANNELS; i++)
      w_n = w_n + NW'(edge_pulse[i]);
  end

  // Clear reloads with this cycle's events so none are lost.
  always_comb begin
    w_sum = SW'(w_n) +
            (count_clear ? SW'(0) : SW'(r_count));
    if (w_sum > SW'(CMAX))
      w_count_nxt = CMAX;
    else
      w_count_nxt = w_sum[COUNT_WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_flags <= '0;
      r_count <= '0;
    end else begin
      r_flags <= (r_flags & ~flag_clear) | edge_pulse;
      r_count <= w_count_nxt;
    end
  end

  assign level       = r_level;
  assign rise_pulse  = r_rise;
  assign fall_pulse  = r_fall;
  assign flags       = r_flags;
  assign irq         = |r_flags;
  assign event_count = r_count;

endmodule

// File: tb/tb_edge_detect_multi.sv
// Bench for edge_detect_multi: directed scenarios plus random
// stimulus, all checked against a window-based reference model.
module tb_edge_detect_multi;

  localparam int CH   = 8;
  localparam int S    = 2;
  localparam int F    = 4;
  localparam int CWID = 4;
  localparam int CMAX = (1 << CWID) - 1;

  logic            clk;
  logic            reset_n;
  logic [CH-1:0]   din;
  logic [CH-1:0]   rise_en;
  logic [CH-1:0]   fall_en;
  logic [CH-1:0]   flag_clear;
  logic            count_clear;
  logic [CH-1:0]   level;
  logic [CH-1:0]   rise_pulse;
  logic [CH-1:0]   fall_pulse;
  logic [CH-1:0]   edge_pulse;
  logic [CH-1:0]   flags;
  logic            irq;
  logic [CWID-1:0] event_count;

  int n_checks = 0;
  int n_errors = 0;

  edge_detect_multi #(
    .CHANNELS(CH), .SYNC_STAGES(S),
    .FILTER_CYCLES(F), .COUNT_WIDTH(CWID)
  ) dut (
    .clk(clk), .reset_n(reset_n), .in(din),
    .rise_en(rise_en), .fall_en(fall_en),
    .flag_clear(flag_clear), .count_clear(count_clear),
    .level(level), .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse), .edge_pulse(edge_pulse),
    .flags(flags), .irq(irq), .event_count(event_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: level flips once the last F post-sync
  // samples all disagree with it.
  logic [CH-1:0] m_level, m_rise, m_fall, m_flags;
  int            m_cnt;
  logic [CH-1:0] m_dq[$];
  logic [CH-1:0] m_win[$];

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic mdl_reset();
    m_level = '0; m_rise = '0; m_fall = '0;
    m_flags = '0; m_cnt = 0;
    m_dq = {};
    m_win = {};
    repeat (S) m_dq.push_back('0);
  endtask

  function automatic logic [CH-1:0] mdl_edge();
    return (m_rise & rise_en) | (m_fall & fall_en);
  endfunction

  task automatic mdl_step();
    logic [CH-1:0] e, pre, nl;
    int n;
    bit all;
    e = mdl_edge();
    m_flags = (m_flags & ~flag_clear) | e;
    n = $countones(e);
    m_cnt = count_clear ? n : m_cnt + n;
    if (m_cnt > CMAX) m_cnt = CMAX;
    pre = m_dq.pop_front();
    m_dq.push_back(din);
    m_win.push_back(pre);
    if (m_win.size() > F) void'(m_win.pop_front());
    nl = m_level;
    if (m_win.size() == F) begin
      for (int c = 0; c < CH; c++) begin
        all = 1'b1;
        foreach (m_win[k])
          if (m_win[k][c] == m_level[c]) all = 1'b0;
        if (all) nl[c] = ~m_level[c];
      end
    end
    m_rise = nl & ~m_level;
    m_fall = ~nl & m_level;
    m_level = nl;
  endtask

  task automatic compare_all();
    check("level", level, m_level);
    check("rise_pulse", rise_pulse, m_rise);
    check("fall_pulse", fall_pulse, m_fall);
    check("edge_pulse", edge_pulse, mdl_edge());
    check("flags", flags, m_flags);
    check("irq", irq, |m_flags);
    check("event_count", event_count, m_cnt);
  endtask

  task automatic tick();
    @(posedge clk);
    mdl_step();
    #1;
    compare_all();
  endtask

  int  rp, fp, ep, lv;
  bit  found;

  initial begin
    reset_n = 1'b0; din = 8'hFF;
    rise_en = 8'hFF; fall_en = 8'h00;
    flag_clear = '0; count_clear = 1'b0;
    mdl_reset();
    #12;
    compare_all();
    reset_n = 1'b1;

    // Reset release latency
    repeat (5) tick();
    check("lat_e5_level", level, 8'h00);
    tick();
    check("lat_e6_level", level, 8'hFF);
    check("lat_e6_rise", rise_pulse, 8'hFF);
    tick();
    check("lat_e7_rise", rise_pulse, 8'h00);
    check("lat_flags", flags, 8'hFF);
    check("lat_irq", irq, 1'b1);
    check("lat_count", event_count, 8);

    // Glitch rejection
    din = 8'h00;
    repeat (12) tick();
    din[0] = 1'b1;
    lv = 0; rp = 0;
    repeat (3) begin
      tick(); lv += level[0]; rp += rise_pulse[0];
    end
    din[0] = 1'b0;
    repeat (10) begin
      tick(); lv += level[0]; rp += rise_pulse[0];
    end
    check("glitch_level", lv, 0);
    check("glitch_rise", rp, 0);
    din[0] = 1'b1;
    rp = 0;
    repeat (4) begin
      tick(); rp += rise_pulse[0];
    end
    din[0] = 1'b0;
    repeat (10) begin
      tick(); rp += rise_pulse[0];
    end
    check("accept_rise", rp, 1);

    // Edge-mode qualification on channel 1
    fall_en = 8'h02; rise_en = 8'hFD;
    count_clear = 1'b1;
    tick();
    count_clear = 1'b0;
    rp = 0; fp = 0; ep = 0;
    din[1] = 1'b1;
    repeat (10) begin
      tick(); rp += rise_pulse[1];
      fp += fall_pulse[1]; ep += edge_pulse[1];
    end
    din[1] = 1'b0;
    repeat (12) begin
      tick(); rp += rise_pulse[1];
      fp += fall_pulse[1]; ep += edge_pulse[1];
    end
    check("mode_rise", rp, 1);
    check("mode_fall", fp, 1);
    check("mode_edge", ep, 1);
    check("mode_count", event_count, 1);

    // Flag clear racing a new edge
    flag_clear = 8'hFF;
    tick();
    flag_clear = 8'h00;
    fall_en = 8'h06;
    din[2] = 1'b1;
    repeat (10) tick();
    check("race_set", flags[2], 1'b1);
    din[2] = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 12 && !found; k++) begin
      tick();
      if (mdl_edge() & 8'h04) found = 1'b1;
    end
    check("race_edge_seen", found, 1'b1);
    flag_clear = 8'h04;
    tick();
    check("race_set_wins", flags[2], 1'b1);
    tick();
    check("race_cleared", flags[2], 1'b0);
    check("race_irq", irq, 1'b0);
    flag_clear = 8'h00;

    // Counter saturation and clear-with-events
    rise_en = 8'hFF; fall_en = 8'h7E;
    count_clear = 1'b1;
    tick();
    count_clear = 1'b0;
    repeat (20) begin
      din[3] = ~din[3];
      repeat (7) tick();
    end
    repeat (8) tick();
    check("sat_count", event_count, 15);
    din[6:4] = 3'b111;
    found = 1'b0;
    for (int k = 0; k < 12 && !found; k++) begin
      tick();
      if (m_rise[6:4] == 3'b111) found = 1'b1;
    end
    check("clr3_seen", found, 1'b1);
    count_clear = 1'b1;
    tick();
    count_clear = 1'b0;
    check("clr3_count", event_count, 3);

    // Async reset in the middle of filtering
    flag_clear = 8'hFF;
    tick();
    flag_clear = 8'h00;
    din[0] = 1'b1; din[2] = 1'b1;
    repeat (10) tick();
    check("pre_rst_flags", flags, 8'h05);
    din[7] = 1'b1;
    repeat (4) tick();
    reset_n = 1'b0;
    mdl_reset();
    #1;
    check("arst_level", level, 8'h00);
    check("arst_flags", flags, 8'h00);
    check("arst_irq", irq, 1'b0);
    check("arst_count", event_count, 0);
    check("arst_pulses", {rise_pulse, fall_pulse}, 16'h0);
    #3;
    reset_n = 1'b1;
    repeat (5) tick();
    check("rearm_e5_level", level, 8'h00);
    tick();
    check("rearm_e6_level", level, 8'hF5);

    // Random stimulus
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(3) == 0)
        din = din ^ (8'h01 << $urandom_range(7));
      if ($urandom_range(15) == 0) rise_en = 8'($urandom);
      if ($urandom_range(15) == 0) fall_en = 8'($urandom);
      flag_clear = ($urandom_range(7) == 0) ?
                   8'($urandom) : 8'h00;
      count_clear = ($urandom_range(40) == 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/edge_detect_multi.md
Name: edge_detect_multi

Overview:
- Multi-channel, parametrised edge detector for asynchronous inputs such as SPI/USB control lines and strap pins.
- Each channel is synchronised, glitch-filtered with a configurable stability window, and edge-detected. Each channel can qualify rising edges, falling edges or both.
- Qualified edges produce single-cycle pulses, per-channel sticky flags with write-one-to-clear, an interrupt line and a saturating aggregate event counter.
- Sits between raw pins and the capture/control logic.

Parameters:
- CHANNELS, 8, number of independent input channels (>=1).
- SYNC_STAGES, 2, synchroniser flops per channel (>=2).
- FILTER_CYCLES, 4, consecutive cycles a new value must be stable before acceptance; 0 disables the filter.
- COUNT_WIDTH, 16, width of the aggregate event counter.

Ports:
- clk  input  1  single system clock; all state on posedge.
- reset_n  input  1  asynchronous, active-low reset.
- in  input  CHANNELS  raw asynchronous inputs.
- rise_en  input  CHANNELS  per-channel: qualify rising edges.
- fall_en  input  CHANNELS  per-channel: qualify falling edges.
- flag_clear  input  CHANNELS  write-one-to-clear for sticky flags; sampled each cycle.
- count_clear  input  1  synchronous clear of event_count.
- level  output  CHANNELS  filtered, synchronised level.
- rise_pulse  output  CHANNELS  one-cycle pulse on filtered 0->1, unqualified.
- fall_pulse  output  CHANNELS  one-cycle pulse on filtered 1->0, unqualified.
- edge_pulse  output  CHANNELS  (rise_pulse & rise_en) | (fall_pulse & fall_en).
- flags  output  CHANNELS  sticky qualified-edge flags.
- irq  output  1  OR of flags.
- event_count  output  COUNT_WIDTH  saturating count of qualified edges.

Behaviour:
- Reset (reset_n low, async):
  - Synchroniser flops, filter counters, level, all pulses, flags, irq and event_count go to 0.
  - Outputs hold 0 until the first clk edge after reset_n deasserts.
  - A reset asserted mid-filter discards partial counts.
- Synchroniser: sync_q is the output of SYNC_STAGES flops per channel. No logic is permitted between stages.
- Filter, FILTER_CYCLES >= 1 (per channel counter, width clog2(FILTER_CYCLES+1)):
  - If sync_q == level: counter <= 0.
  - Else if counter == FILTER_CYCLES-1: level <= sync_q and counter <= 0.
  - Else: counter increments.
  - Any return to the old value before acceptance resets the counter. Glitches shorter than FILTER_CYCLES cycles (post-sync) never reach level.
- Filter, FILTER_CYCLES == 0: level <= sync_q every cycle.
- Latency: a clean input step reaches level after SYNC_STAGES+FILTER_CYCLES clk edges, or SYNC_STAGES+1 when the filter is disabled.
- Pulses:
  - rise_pulse and fall_pulse are registered, asserted in exactly the cycle level first shows the new value, for one cycle.
  - A held input never re-pulses.
  - edge_pulse is combinational from the registered pulses and the enables.
- Flags: flags <= (flags & ~flag_clear) | edge_pulse.
  - If an edge and a clear coincide on a channel, set wins.
  - irq is combinational OR of flags.
- Event counter, n = popcount(edge_pulse) (0..CHANNELS):
  - count_clear high: event_count <= n, so coincident events are not lost.
  - Otherwise: event_count <= min(event_count + n, 2^COUNT_WIDTH-1). It saturates at all-ones and never wraps.
  - Internal sum width is COUNT_WIDTH+1.
- Enable changes take effect combinationally on edge_pulse. There is no retroactive flagging of earlier edges.
- Channels are fully independent. Simultaneous edges on all channels are all counted and flagged in the same cycle.

Test Plan:
- Reset/latency: reset_n low with in=8'hFF, release, hold; FILTER_CYCLES=4, SYNC_STAGES=2 -> level=8'hFF on the 6th clk edge after release. rise_pulse=8'hFF for exactly 1 cycle; rise_en=8'hFF -> flags=8'hFF, irq=1, event_count=8.
- Glitch reject: in[0] high for 3 cycles, then low -> level[0] stays 0, no pulses. In high for 4 cycles -> level[0] rises, rise_pulse[0] for 1 cycle.
- Mode qualify: channel 1, rise_en=0, fall_en=1; toggle 0->1->0 with 10-cycle holds -> rise_pulse[1] and fall_pulse[1] each fire once; edge_pulse[1] fires only on the fall; event_count +1.
- Flag clear race: flags[2]=1, then assert flag_clear[2] in the same cycle as a new edge_pulse[2] -> flags[2] stays 1. Clear alone on the next cycle -> flags[2]=0, irq=0.
- Counter saturation: COUNT_WIDTH=4, generate 20 single-channel qualified edges -> event_count stops at 15. count_clear coincident with 3 channel edges -> event_count=3.
- Async reset mid-operation: assert reset_n low for a half cycle while a filter count is at 2 and flags=8'h05 -> all outputs 0 immediately. After release, the stable input is re-accepted only after the full 6-cycle latency.
